serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit count; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to add a, b, cin; sampled on clk edge.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed (state RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until the next done.
REQ-011 SHALL have port cout  output  1  registered carry-out of MSB, held until the next done.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; the per-bit adder SHALL be one full_adder instance (a, b, cin -> sum, cout).
REQ-013 IDLE: start=1 at an edge -> load A/B shift registers from a/b, carry flop from cin, bit counter to 0, go to RUN.
REQ-014 RUN: each edge SHALL feed the shift-register LSBs and the carry flop into the full adder, shift A/B right by one, shift the sum bit into the result shift register MSB, store cout in the carry flop, and increment the counter.
REQ-015 RUN: the edge that processes bit WIDTH-1 SHALL copy the result shift register (including that bit) to sum, the full-adder cout to cout, and go to DONE.
REQ-016 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH), exactly WIDTH cycles in RUN.
REQ-017 DONE: done=1 for exactly one cycle; next edge -> IDLE, unless start=1, in which case the operands are loaded and the state goes to RUN (back-to-back).
REQ-018 start in RUN SHALL be ignored; operands, counter, and outputs are unaffected.
REQ-019 a, b, cin changes while not accepting start SHALL not affect the operation in progress.
REQ-020 sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of a + b + cin (unsigned).
REQ-021 WIDTH=1: RUN SHALL last one cycle, with the same done timing as REQ-016.
REQ-022 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both SHALL be registered-state decodes with no combinational path from start.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the shift registers, carry flop, and counter.
REQ-024 rst_n asserted mid-RUN SHALL abandon the operation with no done pulse; start is first accepted at the first edge with rst_n high.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output port ovf (1 bit) = signed overflow = carry into MSB XOR carry out of MSB, updated and held with cout and cleared by reset.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 WIDTH=8, a=0x05, b=0x03, cin=1, start pulse -> busy for 8 cycles, done 8 cycles after start edge, sum=0x09, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 (OVF_EN); a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-029 Start with a=0x10, b=0x20; then start=1 with a=0xFF during RUN -> ignored, result sum=0x30, single done pulse.
REQ-030 rst_n low at RUN cycle 4 -> all outputs 0 at once, no done; after release, a=0x01, b=0x01 -> sum=0x02 after 8 cycles.
REQ-031 start held high through the DONE cycle with a=0x0A, b=0x05 -> second operation begins with no IDLE cycle; second done 9 cycles after the first, sum=0x0F.
REQ-032 Exhaustive sweep at WIDTH=4 of all a, b, cin combinations -> sum/cout match the reference add every time.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, WIDTH cycles per add through one full_adder.
// Optional `SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic             carry, fa_sum, fa_cout, last, load;
    logic [CW-1:0]    cnt;

    full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(fa_sum), .cout(fa_cout));

    assign last    = cnt == CW'(WIDTH - 1);
    assign load    = start && state != RUN;
    // shifts instead of slices so WIDTH=1 elaborates cleanly
    assign res_nxt = (res_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // at the MSB step the carry flop holds the carry into the MSB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                           ovf <= 1'b0;
        else if (!load && state == RUN && last) ovf <= carry ^ fa_cout;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder at WIDTH 8, 4 and 1
// against plain integer addition.
module tb_serial_adder;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic s8 = 0, c8 = 0, bz8, d8, co8;
    logic [7:0] a8 = 0, b8 = 0, sm8;
    logic s4 = 0, c4 = 0, bz4, d4, co4;
    logic [3:0] a4 = 0, b4 = 0, sm4;
    logic s1 = 0, c1 = 0, a1 = 0, b1 = 0, bz1, d1, co1, sm1;
`ifdef SERIAL_ADDER_OVF_EN
    logic ov8, ov4, ov1;
`endif

    int n_chk = 0, n_pass = 0;

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(bz8), .done(d8), .sum(sm8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ov8)
`endif
    );
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
        .busy(bz4), .done(d4), .sum(sm4), .cout(co4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ov4)
`endif
    );
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(bz1), .done(d1), .sum(sm1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ov1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit poke);
        logic [8:0] r;
        int lat, bc;
        r = {1'b0, x} + 9'(y) + 9'(c);
        lat = 0;
        bc = 0;
        @(negedge clk); s8 = 1; a8 = x; b8 = y; c8 = c;
        @(negedge clk); s8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        while (!d8 && lat < 40) begin
            if (bz8) bc++;
            s8 = poke && lat == 3;
            if (s8) a8 = 8'hFF;
            @(negedge clk);
            lat++;
        end
        s8 = 0;
        check("lat8", lat, 8);
        check("busy8", bc, 8);
        check("sum8", sm8, r[7:0]);
        check("cout8", co8, r[8]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", ov8, x[7] == y[7] && r[7] != x[7]);
`endif
        @(negedge clk);
        check("pulse8", d8, 0);
        check("idle8", bz8, 0);
        check("hold8", sm8, r[7:0]);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] r;
        int lat;
        r = {1'b0, x} + 5'(y) + 5'(c);
        lat = 0;
        @(negedge clk); s4 = 1; a4 = x; b4 = y; c4 = c;
        @(negedge clk); s4 = 0; a4 = ~x; b4 = ~y;
        while (!d4 && lat < 20) begin @(negedge clk); lat++; end
        check("lat4", lat, 4);
        check("sum4", {sm4, co4}, {r[3:0], r[4]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf4", ov4, x[3] == y[3] && r[3] != x[3]);
`endif
    endtask

    task automatic op1(input logic x, input logic y, input logic c);
        logic [1:0] r;
        int lat;
        r = 2'(x) + 2'(y) + 2'(c);
        lat = 0;
        @(negedge clk); s1 = 1; a1 = x; b1 = y; c1 = c;
        @(negedge clk); s1 = 0; a1 = ~x; b1 = ~y;
        check("busy1", bz1, 1);
        while (!d1 && lat < 20) begin @(negedge clk); lat++; end
        check("lat1", lat, 1);
        check("sum1", {sm1, co1}, {r[0], r[1]});
    endtask

    initial begin
        int k;
        bit seen;
        #2 rst_n = 0;
        #1;
        check("rst_busy", bz8, 0);
        check("rst_done", d8, 0);
        check("rst_sum", {sm8, co8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        op8(8'h05, 8'h03, 1'b1, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'h10, 8'h20, 1'b0, 1);
        for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom));
        op8(8'hC3, 8'h5A, 1'b1, 0);
        // reset in the fourth RUN cycle
        @(negedge clk); s8 = 1; a8 = 8'h33; b8 = 8'h44; c8 = 0;
        @(negedge clk); s8 = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_busy", bz8, 0);
        check("mid_rst_out", {d8, sm8, co8}, 0);
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= d8; end
        rst_n = 1;
        repeat (10) begin @(negedge clk); seen |= d8; end
        check("rst_nodone", seen, 0);
        op8(8'h01, 8'h01, 1'b0, 0);
        // start held through DONE: reload without an IDLE cycle
        @(negedge clk); s8 = 1; a8 = 8'h0A; b8 = 8'h05; c8 = 0;
        k = 0;
        while (!d8 && k < 40) begin @(negedge clk); k++; end
        check("b2b_first", d8, 1);
        @(negedge clk); s8 = 0; a8 = 8'hEE; b8 = 8'hEE;
        check("b2b_busy", bz8, 1);
        k = 1;
        while (!d8 && k < 40) begin @(negedge clk); k++; end
        check("b2b_gap", k, 9);
        check("b2b_sum", {sm8, co8}, {8'h0F, 1'b0});
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) op4(4'(x), 4'(y), 1'(c));
        for (int i = 0; i < 8; i++) op1(i[2], i[1], i[0]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
